// File: rtl/shift_arbiter2.sv
// shift_arbiter2 -- two-requester front end for one shared 32-bit barrel shifter.
//
// The module accepts one operation at a time. Arbitration is round-robin, and the
// requests use valid/ready handshakes. The operands are registered at accept, and the
// shifter output is captured into rsp_data. The result goes back only to the requester
// that issued the operation. Each requester has a saturating count of completed
// operations.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   req_valid/req_ready per-requester request handshake (req_ready is combinational)
//   req_a0/b0/op0       requester 0 operand, shift amount, op (00 asr, 01 lsr, 1x lsl)
//   req_a1/b1/op1       requester 1 operand, shift amount, op
//   rsp_valid/rsp_ready per-requester response handshake
//   rsp_data            shared result bus, qualified by rsp_valid
//   busy                high whenever an operation is in flight (EXEC or RESP)
//   ops_cnt0/ops_cnt1   saturating completed-operation counters

// barrelshifter32 -- combinational 32-bit shifter, 5 log stages.
//   a: operand, b: amount 0..31, op: 00 arith right, 01 logic right, 1x logic left
//   y: result
module barrelshifter32 (
    input  logic [31:0] a,
    input  logic [4:0]  b,
    input  logic [1:0]  op,
    output logic [31:0] y
);
    logic             left;
    logic             fill;
    logic [31:0]      a_rev;
    logic [31:0]      src;
    logic [31:0]      res_rev;
    logic [5:0][31:0] stg;

    assign left = op[1];
    // Only the arithmetic right shift fills with the sign bit. A left shift is done
    // by bit-reversing the operand, doing a right shift, and reversing back, so it
    // must always fill with zeros.
    assign fill = (op == 2'b00) & a[31];

    for (genvar i = 0; i < 32; i++) begin : g_rev
        assign a_rev[i]   = a[31-i];
        assign res_rev[i] = stg[5][31-i];
    end

    assign src    = left ? a_rev : a;
    assign stg[0] = src;

    for (genvar k = 0; k < 5; k++) begin : g_stage
        localparam int S = 1 << k;
        assign stg[k+1] = b[k] ? {{S{fill}}, stg[k][31:S]} : stg[k];
    end

    assign y = left ? res_rev : stg[5];
endmodule

module shift_arbiter2 #(
    parameter int DATA_W = 32,  // fixed by the shifter
    parameter int SH_W   = 5,   // fixed by the shifter
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [SH_W-1:0]   req_b0,
    input  logic [1:0]        req_op0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [SH_W-1:0]   req_b1,
    input  logic [1:0]        req_op1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_cnt0,
    output logic [CNT_W-1:0]  ops_cnt1
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              rr_ptr;
    logic [1:0]        grant;
    logic              accept;
    logic              rsp_done;
    logic              owner;
    logic [DATA_W-1:0] a_q;
    logic [SH_W-1:0]   b_q;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] sh_y;

    // Round-robin grant. When both requesters are valid, the one named by rr_ptr wins.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = (state_q == IDLE) ? grant : 2'b00;
    assign accept    = |req_ready;
    // Only the owner's rsp_ready can complete the response.
    assign rsp_done  = (state_q == RESP) && rsp_ready[owner];
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = EXEC;
            EXEC:                  state_d = RESP;
            RESP:    if (rsp_done) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    barrelshifter32 u_shift (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (sh_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rsp_data  <= '0;
            rsp_valid <= 2'b00;
            ops_cnt0  <= '0;
            ops_cnt1  <= '0;
        end else begin
            if (accept) begin
                owner  <= grant[1];
                rr_ptr <= ~grant[1];
                a_q    <= grant[1] ? req_a1  : req_a0;
                b_q    <= grant[1] ? req_b1  : req_b0;
                op_q   <= grant[1] ? req_op1 : req_op0;
            end
            if (state_q == EXEC) begin
                rsp_data  <= sh_y;
                rsp_valid <= owner ? 2'b10 : 2'b01;
            end
            if (rsp_done) begin
                rsp_valid <= 2'b00;
                if (!owner && ops_cnt0 != '1) ops_cnt0 <= ops_cnt0 + 1'b1;
                if ( owner && ops_cnt1 != '1) ops_cnt1 <= ops_cnt1 + 1'b1;
            end
        end
    end
endmodule
